alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have port: CLK  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: RST  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable  input  1 each  unit enables from the decoder unit.
REQ-004 SHALL have ports: Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT  input  16 each  unit results.
REQ-005 SHALL have port: Carry_OUT  input  1  arithmetic carry.
REQ-006 SHALL have ports: In_Valid  input  1  and In_Ready  output  1  upstream handshake.
REQ-007 SHALL have ports: Out_Valid  output  1  and Out_Ready  input  1  downstream handshake.
REQ-008 SHALL have port: Out_Data  output  16  head-of-queue result.
REQ-009 SHALL have ports: Out_Carry  output  1, Out_Zero  output  1, Out_Unit  output  4  head-entry flags, Out_Unit one-hot {Shift,CMP,Logic,Arith}, bit 0 = Arith.
REQ-010 SHALL have ports: Err_Clr  input  1  and Illegal_Err  output  1  sticky illegal-enable flag.
REQ-011 SHALL have port: Fifo_Count  output  3  occupied entries, 0..4.

Function
REQ-012 SHALL store results in a 4-entry FIFO; each entry = {Data[15:0], Carry, Zero, Unit[3:0]}.
REQ-013 SHALL accept an input only on a rising edge where In_Valid=1 and In_Ready=1.
REQ-014 SHALL drive In_Ready = 1 iff Fifo_Count < 4, with no full-bypass: push is refused when full even if a pop occurs the same cycle.
REQ-015 SHALL treat an input as legal only when exactly one enable is high.
REQ-016 SHALL, on a legal accept, write Data = result of the enabled unit, Unit = the enable vector, Carry = Carry_OUT if Arith_Enable else 0, and Zero = (Data == 16'h0000).
REQ-017 SHALL, on an accept with zero or more than one enable high, write no entry, leave Fifo_Count unchanged, and set Illegal_Err on that edge.
REQ-018 SHALL clear Illegal_Err on an edge where Err_Clr=1, except that a simultaneous illegal accept keeps it set (set wins).
REQ-019 SHALL pop the head entry on an edge where Out_Valid=1 and Out_Ready=1.
REQ-020 SHALL drive Out_Valid = 1 iff Fifo_Count > 0.
REQ-021 SHALL make an accepted entry visible on the outputs one cycle after acceptance when the FIFO was empty, with no combinational path from inputs to outputs.
REQ-022 SHALL hold Out_Data, Out_Carry, Out_Zero and Out_Unit stable while Out_Valid=1 and Out_Ready=0.
REQ-023 SHALL drive Out_Data, Out_Carry, Out_Zero and Out_Unit to 0 while the FIFO is empty.
REQ-024 SHALL, on simultaneous push and pop with 1..3 entries, leave Fifo_Count unchanged and preserve order.
REQ-025 SHALL wrap read/write pointers modulo 4 and preserve strict FIFO order across wrap.
REQ-026 SHALL ignore Out_Ready while empty, with no underflow and no count change.

Reset
REQ-027 SHALL, when RST=1, immediately clear pointers, Fifo_Count=0, Illegal_Err=0 and Out_Valid=0, drive In_Ready=1, and drive Out_Data, Out_Carry, Out_Zero and Out_Unit to 0.
REQ-028 SHALL discard all queued entries on reset asserted mid-operation, and SHALL accept no transfer on any edge while RST=1.
REQ-029 SHALL need no storage-array clear; entries beyond Fifo_Count are never visible.

Verification
REQ-030 Single arith: Arith_Enable=1, Arith_OUT=16'hFFFF, Carry_OUT=1, one-cycle In_Valid, Out_Ready=0 -> next cycle Out_Valid=1, Out_Data=FFFF, Out_Carry=1, Out_Zero=0, Out_Unit=0001, Fifo_Count=1.
REQ-031 Fill/full: 5 back-to-back legal pushes (Logic_OUT=1,2,3,4,5), Out_Ready=0 -> In_Ready=0 after 4th, 5th not accepted, Fifo_Count=4; then Out_Ready=1 -> outputs 1,2,3,4 in order, then Out_Valid=0 and Out_Data=0.
REQ-032 Illegal: Logic_Enable=CMP_Enable=1 with In_Valid -> Fifo_Count unchanged, Illegal_Err=1; Err_Clr=1 alone -> 0; Err_Clr plus illegal accept same edge -> stays 1.
REQ-033 Flags and wrap: 10 pushes alternating Shift_OUT=0 and CMP_OUT=7, with continuous pop at one push per cycle -> Fifo_Count steady, Out_Zero=1/0 alternating, Out_Unit 1000/0100, Out_Carry=0, order intact.
REQ-034 Reset mid-run: 3 entries queued and Illegal_Err=1, RST pulsed between edges -> outputs and Fifo_Count=0 and In_Ready=1 before the next edge; first post-reset push appears as sole entry.

Source files
------------

// File: rtl/alu_result_stage.sv
// Result collection stage: queues single-unit ALU results in a 4-entry FIFO
// with carry/zero/unit flags and a sticky error for malformed enable patterns.
module alu_result_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Arith_Enable,
    input  logic        Logic_Enable,
    input  logic        CMP_Enable,
    input  logic        Shift_Enable,
    input  logic [15:0] Arith_OUT,
    input  logic [15:0] Logic_OUT,
    input  logic [15:0] CMP_OUT,
    input  logic [15:0] Shift_OUT,
    input  logic        Carry_OUT,
    input  logic        In_Valid,
    output logic        In_Ready,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [15:0] Out_Data,
    output logic        Out_Carry,
    output logic        Out_Zero,
    output logic [3:0]  Out_Unit,
    input  logic        Err_Clr,
    output logic        Illegal_Err,
    output logic [2:0]  Fifo_Count
);

    localparam int ENTRY_W = 22;

    logic [ENTRY_W-1:0] r_mem [0:3];
    logic [1:0]         r_wr_ptr;
    logic [1:0]         r_rd_ptr;
    logic [2:0]         r_count;
    logic               r_illegal_err;

    logic [3:0]         w_en;
    logic               w_legal;
    logic [15:0]        w_result;
    logic               w_carry;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;

    function automatic logic is_onehot(input logic [3:0] en);
        case (en)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: is_onehot = 1'b1;
            default:                            is_onehot = 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] select_result(
        input logic [3:0]  en,
        input logic [15:0] arith,
        input logic [15:0] logic_r,
        input logic [15:0] cmp,
        input logic [15:0] shift
    );
        case (en)
            4'b0001: select_result = arith;
            4'b0010: select_result = logic_r;
            4'b0100: select_result = cmp;
            4'b1000: select_result = shift;
            default: select_result = 16'h0000;
        endcase
    endfunction

    assign w_en     = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
    assign w_legal  = is_onehot(w_en);
    assign w_result = select_result(w_en, Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT);
    assign w_carry  = Arith_Enable & Carry_OUT;
    assign w_entry  = {w_result, w_carry, (w_result == 16'h0000), w_en};

    // Handshake: no full-bypass, so a pop never frees a slot for the same edge.
    assign w_in_ready  = (r_count < 3'd4);
    assign w_out_valid = (r_count != 3'd0);
    assign w_accept    = In_Valid & w_in_ready;
    assign w_push      = w_accept & w_legal;
    assign w_pop       = w_out_valid & Out_Ready;

    // Storage needs no reset: slots beyond the count are never presented.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr      <= 2'd0;
            r_rd_ptr      <= 2'd0;
            r_count       <= 3'd0;
            r_illegal_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_accept && !w_legal) begin
                r_illegal_err <= 1'b1;
            end else if (Err_Clr) begin
                r_illegal_err <= 1'b0;
            end
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign In_Ready    = w_in_ready;
    assign Out_Valid   = w_out_valid;
    assign Out_Data    = w_out_valid ? w_head[21:6] : 16'h0000;
    assign Out_Carry   = w_out_valid ? w_head[5]    : 1'b0;
    assign Out_Zero    = w_out_valid ? w_head[4]    : 1'b0;
    assign Out_Unit    = w_out_valid ? w_head[3:0]  : 4'b0000;
    assign Illegal_Err = r_illegal_err;
    assign Fifo_Count  = r_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: stimulus queues hand-written expected
// entries, a negedge monitor compares them as the DUT pops its head entry.
module tb_alu_result_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
    logic        Carry_OUT;
    logic        In_Valid;
    logic        In_Ready;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [15:0] Out_Data;
    logic        Out_Carry;
    logic        Out_Zero;
    logic [3:0]  Out_Unit;
    logic        Err_Clr;
    logic        Illegal_Err;
    logic [2:0]  Fifo_Count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [21:0] exp_q [$];

    alu_result_stage dut (
        .CLK(CLK), .RST(RST),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
        .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
        .Carry_OUT(Carry_OUT),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_Data(Out_Data), .Out_Carry(Out_Carry), .Out_Zero(Out_Zero),
        .Out_Unit(Out_Unit),
        .Err_Clr(Err_Clr), .Illegal_Err(Illegal_Err),
        .Fifo_Count(Fifo_Count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every edge that will pop must present the oldest expected entry.
    always @(negedge CLK) begin
        if (!RST && Out_Valid && Out_Ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {10'd0, Out_Data, Out_Carry, Out_Zero, Out_Unit}, 32'hFFFF_FFFF);
            end else begin
                check("out_entry", {10'd0, Out_Data, Out_Carry, Out_Zero, Out_Unit},
                      {10'd0, exp_q.pop_front()});
            end
        end
    end

    // Present one input for one edge; en selects which unit outputs the value.
    task automatic send(input logic [3:0] en, input logic [15:0] val, input logic cy,
                        input logic exp_rdy, input int exp_cnt, input logic [21:0] exp_entry);
        Arith_OUT = 16'hA5A5; Logic_OUT = 16'h5A5A; CMP_OUT = 16'h3C3C; Shift_OUT = 16'hC3C3;
        if (en[0]) Arith_OUT = val;
        if (en[1]) Logic_OUT = val;
        if (en[2]) CMP_OUT   = val;
        if (en[3]) Shift_OUT = val;
        {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable} = en;
        Carry_OUT = cy;
        In_Valid  = 1'b1;
        if (exp_rdy && $onehot(en)) exp_q.push_back(exp_entry);
        @(negedge CLK);
        check("in_ready", {31'd0, In_Ready}, {31'd0, exp_rdy});
        if (exp_cnt >= 0) check("count_pre", {29'd0, Fifo_Count}, exp_cnt);
        @(posedge CLK); #1;
        In_Valid = 1'b0;
        {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable} = 4'b0000;
        Carry_OUT = 1'b0;
    endtask

    task automatic drain();
        Out_Ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (Fifo_Count == 3'd0) break;
        end
        check("drain_count", {29'd0, Fifo_Count}, 32'd0);
        check("drain_valid", {31'd0, Out_Valid}, 32'd0);
        check("empty_out", {10'd0, Out_Data, Out_Carry, Out_Zero, Out_Unit}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        @(posedge CLK); #1;
        Out_Ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0; Err_Clr = 1'b0; Carry_OUT = 1'b0;
        {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable} = 4'b0000;
        Arith_OUT = 16'h0; Logic_OUT = 16'h0; CMP_OUT = 16'h0; Shift_OUT = 16'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_count", {29'd0, Fifo_Count}, 32'd0);
        check("rst_in_ready", {31'd0, In_Ready}, 32'd1);
        check("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
        check("rst_err", {31'd0, Illegal_Err}, 32'd0);
        check("rst_out", {10'd0, Out_Data, Out_Carry, Out_Zero, Out_Unit}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Single arithmetic result with carry, held while Out_Ready is low.
        send(4'b0001, 16'hFFFF, 1'b1, 1'b1, 0, {16'hFFFF, 1'b1, 1'b0, 4'b0001});
        @(negedge CLK);
        check("arith_valid", {31'd0, Out_Valid}, 32'd1);
        check("arith_count", {29'd0, Fifo_Count}, 32'd1);
        check("arith_entry", {10'd0, Out_Data, Out_Carry, Out_Zero, Out_Unit}, {10'd0, 16'hFFFF, 1'b1, 1'b0, 4'b0001});
        @(negedge CLK);
        check("arith_hold", {10'd0, Out_Data, Out_Carry, Out_Zero, Out_Unit}, {10'd0, 16'hFFFF, 1'b1, 1'b0, 4'b0001});
        @(posedge CLK); #1;
        drain();

        // Fill to full; fifth push refused, sixth refused even with a pop on the same edge.
        for (int i = 1; i <= 4; i++)
            send(4'b0010, 16'(i), 1'b1, 1'b1, i - 1, {16'(i), 1'b0, 1'b0, 4'b0010});
        send(4'b0010, 16'd5, 1'b0, 1'b0, 4, 22'd0);
        @(negedge CLK);
        check("full_count", {29'd0, Fifo_Count}, 32'd4);
        @(posedge CLK); #1;
        Out_Ready = 1'b1;
        send(4'b0010, 16'd6, 1'b0, 1'b0, 4, 22'd0);
        @(negedge CLK);
        check("full_pop_count", {29'd0, Fifo_Count}, 32'd3);
        @(posedge CLK); #1;
        drain();

        // Illegal enable patterns and the sticky error flag.
        send(4'b0110, 16'h1234, 1'b0, 1'b1, 0, 22'd0);
        @(negedge CLK);
        check("illegal_count", {29'd0, Fifo_Count}, 32'd0);
        check("illegal_set", {31'd0, Illegal_Err}, 32'd1);
        @(posedge CLK); #1;
        Err_Clr = 1'b1;
        @(posedge CLK); #1;
        Err_Clr = 1'b0;
        @(negedge CLK);
        check("err_clear", {31'd0, Illegal_Err}, 32'd0);
        @(posedge CLK); #1;
        send(4'b0000, 16'h0, 1'b0, 1'b1, 0, 22'd0);
        @(negedge CLK);
        check("none_enable_err", {31'd0, Illegal_Err}, 32'd1);
        @(posedge CLK); #1;
        Err_Clr = 1'b1;
        send(4'b1100, 16'h0, 1'b0, 1'b1, 0, 22'd0);
        Err_Clr = 1'b0;
        @(negedge CLK);
        check("set_wins", {31'd0, Illegal_Err}, 32'd1);
        check("illegal_count2", {29'd0, Fifo_Count}, 32'd0);
        @(posedge CLK); #1;
        Err_Clr = 1'b1;
        @(posedge CLK); #1;
        Err_Clr = 1'b0;

        // Streaming with continuous pop: count steady at one, flags alternate, pointers wrap.
        Out_Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) send(4'b1000, 16'h0000, 1'b1, 1'b1, (i == 0) ? 0 : 1, {16'h0000, 1'b0, 1'b1, 4'b1000});
            else            send(4'b0100, 16'h0007, 1'b1, 1'b1, 1, {16'h0007, 1'b0, 1'b0, 4'b0100});
        end
        drain();

        // Reset mid-run with queued entries and the error flag set.
        send(4'b0001, 16'h0011, 1'b1, 1'b1, 0, {16'h0011, 1'b1, 1'b0, 4'b0001});
        send(4'b0010, 16'h0022, 1'b1, 1'b1, 1, {16'h0022, 1'b0, 1'b0, 4'b0010});
        send(4'b0100, 16'h0033, 1'b0, 1'b1, 2, {16'h0033, 1'b0, 1'b0, 4'b0100});
        send(4'b0011, 16'h0044, 1'b0, 1'b1, 3, 22'd0);
        @(negedge CLK);
        check("pre_rst_err", {31'd0, Illegal_Err}, 32'd1);
        @(posedge CLK); #2;
        RST = 1'b1;
        #1;
        check("mid_rst_count", {29'd0, Fifo_Count}, 32'd0);
        check("mid_rst_in_ready", {31'd0, In_Ready}, 32'd1);
        check("mid_rst_valid", {31'd0, Out_Valid}, 32'd0);
        check("mid_rst_err", {31'd0, Illegal_Err}, 32'd0);
        check("mid_rst_out", {10'd0, Out_Data, Out_Carry, Out_Zero, Out_Unit}, 32'd0);
        exp_q.delete();
        #1;
        RST = 1'b0;
        send(4'b0001, 16'h1234, 1'b0, 1'b1, 0, {16'h1234, 1'b0, 1'b0, 4'b0001});
        @(negedge CLK);
        check("post_rst_count", {29'd0, Fifo_Count}, 32'd1);
        check("post_rst_entry", {10'd0, Out_Data, Out_Carry, Out_Zero, Out_Unit}, {10'd0, 16'h1234, 1'b0, 1'b0, 4'b0001});
        @(posedge CLK); #1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
